// File: rtl/ti_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ti_link_pkg
// Description : Shared types and constants for the TI link byte receiver.
// Revision    : 1.0
// ============================================================================
package ti_link_pkg;

    localparam int BITS_PER_BYTE          = 8;
    localparam int BIT_W                  = $clog2(BITS_PER_BYTE);
    localparam int TIMEOUT_CYCLES_DEFAULT = 12000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK0  = 3'd1,
        ST_REL0  = 3'd2,
        ST_ACK1  = 3'd3,
        ST_REL1  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ti_link_sync.sv
`default_nettype none
// ============================================================================
// Module      : ti_link_sync
// Description : Multi-flop level synchroniser, resets to the idle-high level.
// Revision    : 1.0
// ============================================================================
module ti_link_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ti_link_rx.sv
`default_nettype none
// ============================================================================
// Module      : ti_link_rx
// Description : TI two-wire (tip/ring) link byte receiver with ready/valid out.
//               Optional wait-state timeout enabled by TI_LINK_RX_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module ti_link_rx
    import ti_link_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tip_in,
    input  logic       ring_in,
    output logic       tip_oe,
    output logic       ring_oe,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       err
);

    state_t                   r_state, w_state_n;
    logic                     r_tip_oe, w_tip_oe_n;
    logic                     r_ring_oe, w_ring_oe_n;
    logic [BIT_W-1:0]         r_bit_cnt, w_bit_cnt_n;
    logic [BITS_PER_BYTE-1:0] r_shift, w_shift_n;
    logic [BITS_PER_BYTE-1:0] r_data, w_data_n;
    logic                     r_valid, w_valid_n;
    logic                     r_err, w_err_n;
    logic                     r_busy;
    logic                     w_bit_done;
    logic                     w_tip_s, w_ring_s;
    logic                     w_timeout;

    ti_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tip (
        .clk  (clk),
        .rst  (rst),
        .din  (tip_in),
        .dout (w_tip_s)
    );

    ti_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ring (
        .clk  (clk),
        .rst  (rst),
        .din  (ring_in),
        .dout (w_ring_s)
    );

`ifdef TI_LINK_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Counts cycles spent in the current state; never runs in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((w_state_n != r_state) || (r_state == ST_IDLE)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_n   = r_state;
        w_tip_oe_n  = r_tip_oe;
        w_ring_oe_n = r_ring_oe;
        w_bit_cnt_n = r_bit_cnt;
        w_shift_n   = r_shift;
        w_data_n    = r_data;
        w_valid_n   = r_valid && !ready;
        w_err_n     = 1'b0;
        w_bit_done  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_tip_s && !w_ring_s) begin
                    w_err_n     = 1'b1;
                    w_bit_cnt_n = '0;
                    w_shift_n   = '0;
                    w_state_n   = ST_DRAIN;
                end else if (!(r_valid && (r_bit_cnt == '0))) begin
                    // A new byte may only begin once the previous one is taken.
                    if (!w_tip_s) begin
                        w_shift_n   = {1'b0, r_shift[BITS_PER_BYTE-1:1]};
                        w_ring_oe_n = 1'b1;
                        w_state_n   = ST_ACK0;
                    end else if (!w_ring_s) begin
                        w_shift_n   = {1'b1, r_shift[BITS_PER_BYTE-1:1]};
                        w_tip_oe_n  = 1'b1;
                        w_state_n   = ST_ACK1;
                    end
                end
            end
            ST_ACK0: begin
                if (w_tip_s) begin
                    w_ring_oe_n = 1'b0;
                    w_state_n   = ST_REL0;
                end
            end
            ST_REL0:  w_bit_done = w_ring_s;
            ST_ACK1: begin
                if (w_ring_s) begin
                    w_tip_oe_n = 1'b0;
                    w_state_n  = ST_REL1;
                end
            end
            ST_REL1:  w_bit_done = w_tip_s;
            ST_DRAIN: begin
                if (w_tip_s && w_ring_s) begin
                    w_state_n = ST_IDLE;
                end
            end
            default:  w_state_n = ST_IDLE;
        endcase

        if (w_bit_done) begin
            w_state_n   = ST_IDLE;
            w_bit_cnt_n = r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_W'(BITS_PER_BYTE - 1)) begin
                w_data_n  = r_shift;
                w_valid_n = 1'b1;
            end
        end

        if (w_timeout) begin
            w_state_n   = ST_IDLE;
            w_tip_oe_n  = 1'b0;
            w_ring_oe_n = 1'b0;
            w_err_n     = 1'b1;
            w_bit_cnt_n = '0;
            w_shift_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tip_oe  <= 1'b0;
            r_ring_oe <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_tip_oe  <= w_tip_oe_n;
            r_ring_oe <= w_ring_oe_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_shift   <= w_shift_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_err     <= w_err_n;
            r_busy    <= (w_state_n != ST_IDLE);
        end
    end

    assign tip_oe  = r_tip_oe;
    assign ring_oe = r_ring_oe;
    assign data    = r_data;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ti_link_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ti_link_rx
// Description : Self-checking bench: calculator host model driving ti_link_rx.
// Revision    : 1.0
// ============================================================================
module tb_ti_link_rx;

    localparam int TO_CYC = 100;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_tip = 1'b0;
    logic       host_ring = 1'b0;
    logic       tip_in, ring_in;
    logic       tip_oe, ring_oe, valid, busy, err;
    logic       ready = 1'b0;
    logic [7:0] data;

    int         n_tests = 0;
    int         n_fail = 0;
    int         err_pulses = 0;
    bit         rand_ready = 1'b0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    // Open-drain wired lines: low if either side pulls.
    assign tip_in  = !(host_tip || tip_oe);
    assign ring_in = !(host_ring || ring_oe);

    ti_link_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk     (clk),
        .rst     (rst),
        .tip_in  (tip_in),
        .ring_in (ring_in),
        .tip_oe  (tip_oe),
        .ring_oe (ring_oe),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .err     (err)
    );

    // Consumer monitor: a byte is taken on each edge where valid&ready.
    always @(negedge clk) begin
        if (valid && ready) rx_q.push_back(data);
        if (err) err_pulses++;
        n_tests++;
        if (tip_oe && ring_oe) begin
            n_fail++;
            $display("FAIL oe_exclusive: tip_oe=%b ring_oe=%b, required not both 1", tip_oe, ring_oe);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ready(input logic v);
        rand_ready = 1'b0;
        @(posedge clk);
        #1 ready = v;
    endtask

    // sel: 0 = tip_oe, 1 = ring_oe, 2 = busy
    task automatic wait_sig(input int sel, input logic val, input string name);
        logic s;
        bit   found;
        found = 1'b0;
        s     = 1'bx;
        for (int i = 0; i < BUDGET && !found; i++) begin
            s = (sel == 0) ? tip_oe : (sel == 1) ? ring_oe : busy;
            if (s === val) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timed out, observed %b required %b", name, s, val);
        end
    endtask

    task automatic send_bit(input logic b);
        if (!b) begin
            host_tip = 1'b1;
            wait_sig(1, 1'b1, "ack0_ring_oe");
            n_tests++;
            if (tip_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL ack0_order: tip_oe=%b required 0", tip_oe);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            host_tip = 1'b0;
            wait_sig(1, 1'b0, "rel0_ring_oe");
        end else begin
            host_ring = 1'b1;
            wait_sig(0, 1'b1, "ack1_tip_oe");
            n_tests++;
            if (ring_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL ack1_order: ring_oe=%b required 0", ring_oe);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            host_ring = 1'b0;
            wait_sig(0, 1'b0, "rel1_tip_oe");
        end
        repeat (4) @(negedge clk);
        wait_sig(2, 1'b0, "bit_idle");
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp);
        repeat (4) @(negedge clk);
        n_tests++;
        if (rx_q.size() != 1 || rx_q[0] !== exp) begin
            n_fail++;
            $display("FAIL %s: received %0d bytes, first=%h, required 1 byte %h",
                     name, rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, exp);
        end
        rx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({tip_oe, ring_oe, valid, busy, err, data} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_state: oe=%b%b valid=%b busy=%b err=%b data=%h, required all 0",
                     tip_oe, ring_oe, valid, busy, err, data);
        end
    endtask

    task automatic test_basic_a5();
        set_ready(1'b1);
        rx_q.delete();
        send_byte(8'hA5);
        check_rx("byte_a5", 8'hA5);
    endtask

    task automatic test_backpressure();
        bit stalled_ok;
        set_ready(1'b0);
        rx_q.delete();
        send_byte(8'h3C);
        repeat (3) @(negedge clk);
        n_tests++;
        if (valid !== 1'b1 || data !== 8'h3C) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h, required 1 / 3c", valid, data);
        end
        host_ring = 1'b1;
        stalled_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tip_oe !== 1'b0 || valid !== 1'b1 || data !== 8'h3C) stalled_ok = 1'b0;
        end
        n_tests++;
        if (!stalled_ok) begin
            n_fail++;
            $display("FAIL bp_stall: tip_oe=%b valid=%b data=%h, required 0 / 1 / 3c", tip_oe, valid, data);
        end
        set_ready(1'b1);
        wait_sig(0, 1'b1, "bp_resume_ack");
        n_tests++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL bp_consume: received %0d bytes, required 1 byte 3c", rx_q.size());
        end
        rx_q.delete();
        send_byte(8'h81);
        check_rx("bp_next_81", 8'h81);
    endtask

    task automatic test_proto_err();
        bit quiet;
        set_ready(1'b1);
        rx_q.delete();
        err_pulses = 0;
        @(negedge clk);
        host_tip  = 1'b1;
        host_ring = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tip_oe !== 1'b0 || ring_oe !== 1'b0 || valid !== 1'b0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_drain: quiet=%b busy=%b, required 1 / 1", quiet, busy);
        end
        host_tip  = 1'b0;
        host_ring = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++;
        if (err_pulses != 1 || busy !== 1'b0 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL proto_err: err_cycles=%0d busy=%b bytes=%0d, required 1 / 0 / 0",
                     err_pulses, busy, rx_q.size());
        end
    endtask

`ifdef TI_LINK_RX_TIMEOUT_EN
    task automatic test_timeout();
        int hi_cycles;
        set_ready(1'b1);
        rx_q.delete();
        err_pulses = 0;
        host_tip = 1'b1;
        wait_sig(1, 1'b1, "to_ack");
        hi_cycles = 0;
        while (ring_oe === 1'b1 && hi_cycles < 3 * TO_CYC) begin
            hi_cycles++;
            @(negedge clk);
        end
        n_tests++;
        if (hi_cycles != TO_CYC || err_pulses != 1) begin
            n_fail++;
            $display("FAIL timeout: ring_oe held %0d cycles err_cycles=%0d, required %0d / 1",
                     hi_cycles, err_pulses, TO_CYC);
        end
        // The host re-syncs: release, then flush the partial bit with a protocol error.
        host_tip = 1'b0;
        repeat (8) @(negedge clk);
        wait_sig(2, 1'b0, "to_idle");
        host_tip  = 1'b1;
        host_ring = 1'b1;
        repeat (5) @(negedge clk);
        host_tip  = 1'b0;
        host_ring = 1'b0;
        repeat (5) @(negedge clk);
        wait_sig(2, 1'b0, "to_flush_idle");
        rx_q.delete();
        send_byte(8'h55);
        check_rx("to_next_55", 8'h55);
    endtask
`endif

    task automatic test_reset_mid_byte();
        set_ready(1'b1);
        rx_q.delete();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        host_ring = 1'b1;
        wait_sig(0, 1'b1, "rst_bit4_ack");
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (tip_oe !== 1'b0 || ring_oe !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: tip_oe=%b ring_oe=%b valid=%b busy=%b, required all 0",
                     tip_oe, ring_oe, valid, busy);
        end
        host_ring = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_discard: received %0d bytes, required 0", rx_q.size());
        end
        send_byte(8'h12);
        check_rx("rst_next_12", 8'h12);
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         waited;
        rx_q.delete();
        rand_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b);
        end
        set_ready(1'b1);
        waited = 0;
        while (rx_q.size() < exp_q.size() && waited < BUDGET) begin
            waited++;
            @(negedge clk);
        end
        n_tests++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: received %0d bytes, required %0d", rx_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            n_tests++;
            if (rx_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL rand_byte%0d: received %h, required %h", k, rx_q[k], exp_q[k]);
            end
        end
        rx_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_backpressure();
        test_proto_err();
`ifdef TI_LINK_RX_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_byte();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ti_link_rx.md
TI_LINK_RX -- requirements
Module: ti_link_rx

Interface
REQ-001 Parameter SYNC_STAGES, 2, number of synchroniser flops on each of tip_in and ring_in (minimum 2).
REQ-002 Parameter TIMEOUT_CYCLES, 12000000, maximum clk cycles spent in any wait state before abort (used only with TI_LINK_RX_TIMEOUT_EN).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tip_in  input  1  raw tip line level, idle high, asynchronous to clk.
REQ-006 ring_in  input  1  raw ring line level, idle high, asynchronous to clk.
REQ-007 tip_oe  output  1  1 = drive tip low (open-drain); 0 = release.
REQ-008 ring_oe  output  1  1 = drive ring low (open-drain); 0 = release.
REQ-009 data  output  8  received byte, valid while valid=1.
REQ-010 valid  output  1  byte available for the downstream consumer.
REQ-011 ready  input  1  consumer accepts data when valid&ready on a clk edge.
REQ-012 busy  output  1  1 whenever the state is not IDLE.
REQ-013 err  output  1  one-cycle pulse on protocol error or timeout.

Function
REQ-014 All state decisions SHALL use synchronised tip_s/ring_s only; tip_oe, ring_oe, valid, busy and err SHALL be registered.
REQ-015 States: IDLE, ACK0, REL0, ACK1, REL1, DRAIN.
REQ-016 IDLE, tip_s=0, ring_s=1: shift 0 into the byte LSB-first, set ring_oe, go to ACK0.
REQ-017 IDLE, ring_s=0, tip_s=1: shift 1, set tip_oe, go to ACK1.
REQ-018 ACK0: on tip_s=1 clear ring_oe and go to REL0; REL0: on ring_s=1 the bit completes.
REQ-019 ACK1: on ring_s=1 clear tip_oe and go to REL1; REL1: on tip_s=1 the bit completes.
REQ-020 Bit completion: increment the 3-bit bit counter and return to IDLE; on the 8th bit (counter wraps 7->0), load data from the shift register and set valid on the next edge.
REQ-021 valid SHALL hold, with data stable, until valid&ready; it then clears on that edge.
REQ-022 Back-pressure: when valid=1 and bit counter=0, IDLE SHALL NOT start a new bit (no line acknowledged) until valid clears; bits 1..7 of a byte are never stalled.
REQ-023 IDLE with tip_s=0 and ring_s=0: pulse err, clear the bit counter and shift register, go to DRAIN; DRAIN returns to IDLE once tip_s=1 and ring_s=1.
REQ-024 tip_oe and ring_oe SHALL never be 1 simultaneously.
REQ-025 When a byte completes and ready=1 in the same cycle as an older valid byte, the older byte is consumed and the new byte loads with valid held at 1.

Reset
REQ-026 Reset: state=IDLE, tip_oe=0, ring_oe=0, valid=0, data=0x00, busy=0, err=0, bit counter=0, shift register=0, timeout counter=0, synchronisers=1.
REQ-027 Reset asserted mid-byte SHALL release both lines immediately (asynchronously) and discard the partial byte.

Configuration
REQ-028 With TI_LINK_RX_TIMEOUT_EN defined: a counter resets on every state change; if it reaches TIMEOUT_CYCLES in ACK0/REL0/ACK1/REL1/DRAIN, release both lines, pulse err, clear the bit counter and shift register, and go to IDLE.
REQ-029 Without TI_LINK_RX_TIMEOUT_EN: no timeout counter is built; wait states last indefinitely; TIMEOUT_CYCLES is ignored.

Structure
REQ-030 Package ti_link_pkg SHALL hold the state enum, BITS_PER_BYTE=8, and the default TIMEOUT_CYCLES constant.
REQ-031 Sub-module ti_link_sync (SYNC_STAGES-deep, reset-to-1 synchroniser) SHALL be instantiated once per line.

Verification
REQ-032 Calculator model sends 0xA5 with ready=1 -> valid pulses with data=0xA5; ack ordering per REQ-016..019 on every bit.
REQ-033 Send 0x3C with ready=0, then start 0x81 -> 0x81 bit0 is not acknowledged; raise ready -> 0x3C consumed, then 0x81 received intact.
REQ-034 Drive tip=0 and ring=0 from IDLE -> one err pulse, no valid, both oe=0, return to IDLE after both lines go high.
REQ-035 With the macro and TIMEOUT_CYCLES=100, drive tip low and hold it -> ring_oe asserted, then released 100 cycles later with an err pulse; the next byte 0x55 is received correctly.
REQ-036 Assert rst during bit 4 of 0xFF -> both oe=0 immediately, valid=0; after release a full 0x12 is received as 0x12.
